// File: rtl/write_port_arb_pkg.sv
// rtl/write_port_arb_pkg.sv - shared constants and sizing helper for the write port arbiter
package write_port_arb_pkg;

    localparam int DROP_W = 8;
    localparam logic [DROP_W-1:0] DROP_MAX = 8'd255;

    // Address/pointer widths never collapse to zero bits, even for a single entry.
    function automatic int clog2Min1(input int value);
        int width;
        width = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                width = i + 1;
            end
        end
        return (width < 1) ? 1 : width;
    endfunction

endpackage

// File: rtl/write_port_arb_rr_arbiter.sv
// rtl/write_port_arb_rr_arbiter.sv - round-robin one-hot arbiter with internal rotating pointer
module rr_arbiter
    import write_port_arb_pkg::*;
#(
    parameter int NUM_PORTS = 2
) (
    input  logic                 clock,
    input  logic                 resetN,
    input  logic                 stall,
    input  logic [NUM_PORTS-1:0] request,
    output logic [NUM_PORTS-1:0] grant
);

    localparam int PTR_W = clog2Min1(NUM_PORTS);

    logic [PTR_W-1:0] rrPtr;
    logic [PTR_W-1:0] winIdx;
    logic [PTR_W-1:0] nextPtr;
    logic [PTR_W-1:0] idx;
    logic             found;
    int               sum;

    // Search starts at rrPtr and wraps; the first requester found wins.
    always_comb begin
        grant  = '0;
        found  = 1'b0;
        winIdx = '0;
        idx    = '0;
        sum    = 0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            sum = int'(rrPtr) + i;
            if (sum >= NUM_PORTS) begin
                sum = sum - NUM_PORTS;
            end
            idx = PTR_W'(sum);
            if (!found && request[idx] && !stall && resetN) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
                winIdx     = idx;
            end
        end
    end

    always_comb begin
        nextPtr = '0;
        if (int'(winIdx) != NUM_PORTS - 1) begin
            nextPtr = winIdx + PTR_W'(1);
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            rrPtr <= '0;
        end else if (found) begin
            rrPtr <= nextPtr;
        end
    end

endmodule

// File: rtl/write_port_arb.sv
// rtl/write_port_arb.sv - arbitrates per-channel register writes into one registered decoded enable
module write_port_arb
    import write_port_arb_pkg::*;
#(
    parameter int NUM_PORTS        = 2,
    parameter int NUM_REGS         = 32,
    parameter int DATA_W           = 32,
    parameter int ZERO_REG_PROTECT = 1,
    localparam int ADDR_W          = clog2Min1(NUM_REGS)
) (
    input  logic                        clock,
    input  logic                        ctrl_reset,
    input  logic                        ctrl_stall,
    input  logic [NUM_PORTS-1:0]        ctrl_writeEnable,
    input  logic [NUM_PORTS*ADDR_W-1:0] ctrl_writeReg,
    input  logic [NUM_PORTS*DATA_W-1:0] data_writeReg,
    output logic [NUM_PORTS-1:0]        ctrl_grant,
    output logic [NUM_REGS-1:0]         write_portOut,
    output logic [DATA_W-1:0]           data_out,
    output logic [DROP_W-1:0]           drop_count
);

    logic [ADDR_W-1:0]   selAddr;
    logic [DATA_W-1:0]   selData;
    logic [NUM_REGS-1:0] decoded;
    logic                granted;
    logic                dropWrite;

    rr_arbiter #(
        .NUM_PORTS(NUM_PORTS)
    ) u_arbiter (
        .clock  (clock),
        .resetN (ctrl_reset),
        .stall  (ctrl_stall),
        .request(ctrl_writeEnable),
        .grant  (ctrl_grant)
    );

    assign granted = |ctrl_grant;

    always_comb begin
        selAddr = '0;
        selData = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (ctrl_grant[k]) begin
                selAddr = ctrl_writeReg[k*ADDR_W +: ADDR_W];
                selData = data_writeReg[k*DATA_W +: DATA_W];
            end
        end
    end

    // Addresses past the last register, or register 0 when protected, are swallowed.
    always_comb begin
        dropWrite = (int'(selAddr) >= NUM_REGS) ||
                    ((selAddr == '0) && (ZERO_REG_PROTECT == 1));
        decoded   = dropWrite ? '0 : (NUM_REGS'(1) << selAddr);
    end

    always_ff @(posedge clock or negedge ctrl_reset) begin
        if (!ctrl_reset) begin
            write_portOut <= '0;
            data_out      <= '0;
            drop_count    <= '0;
        end else if (granted) begin
            write_portOut <= decoded;
            data_out      <= selData;
            if (dropWrite && (drop_count != DROP_MAX)) begin
                drop_count <= drop_count + 1'b1;
            end
        end else begin
            write_portOut <= '0;
        end
    end

endmodule
